// File: rtl/lock_controller_pkg.sv
// Shared definitions for the keypad lock controller.
//   state_t       : FSM state encoding (also exported on state_o for debug)
//   KEY_STAR/HASH : control key codes
//   is_digit()    : true for key codes 0-9
package lock_pkg;

  typedef enum logic [2:0] {
    LOCKED   = 3'd0,
    ENTRY    = 3'd1,
    UNLOCKED = 3'd2,
    SET_NEW  = 3'd3,
    ALARM    = 3'd4
  } state_t;

  localparam logic [3:0] KEY_STAR   = 4'b1010;
  localparam logic [3:0] KEY_HASH   = 4'b1011;
  localparam int unsigned NUM_DIGITS = 4;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/lock_controller_if.sv
// Keypad / status bundle between the lock controller and its user.
//   key_valid, key : keypress strobe and code (driven by master)
//   unlocked, alarm, fail_cnt, digit_cnt, bad_pulse, state_o : status (driven by slave)
interface lock_controller_if;
  logic       key_valid;
  logic [3:0] key;
  logic       unlocked;
  logic       alarm;
  logic [1:0] fail_cnt;
  logic [2:0] digit_cnt;
  logic       bad_pulse;
  logic [2:0] state_o;

  modport master (
    output key_valid, key,
    input  unlocked, alarm, fail_cnt, digit_cnt, bad_pulse, state_o
  );

  modport slave (
    input  key_valid, key,
    output unlocked, alarm, fail_cnt, digit_cnt, bad_pulse, state_o
  );
endinterface

// File: rtl/lock_controller_pw_store.sv
// Password store: 4 x 4-bit registers.
//   clk, reset            : clock, async active-high reset (clears to 0000)
//   we, waddr, wdata      : single-entry write
//   load, load_data       : parallel load of all four words (wins over we)
//   raddr, rdata          : asynchronous read
module pw_store (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [1:0]      waddr,
  input  logic [3:0]      wdata,
  input  logic            load,
  input  logic [3:0][3:0] load_data,
  input  logic [1:0]      raddr,
  output logic [3:0]      rdata
);

  logic [3:0][3:0] mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else if (load) begin
      mem <= load_data;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lock_controller.sv
// Keypad lock controller: 4-digit code entry, code change, and lockout
// alarm after MAX_FAILS consecutive failed attempts.
//   clk, reset : clock, async active-high reset
//   bus        : keypad input and status outputs (slave side)
module lock_controller
  import lock_pkg::*;
#(
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned MAX_FAILS      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  lock_controller_if.slave      bus
);

  localparam int unsigned CW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  state_t          state;
  logic [1:0]      fail_cnt;
  logic [2:0]      digit_cnt;
  logic            mismatch;
  logic [CW-1:0]   lock_cnt;
  logic [3:0][3:0] staging;
  logic            bad_pulse;

  logic [1:0]      rd_addr;
  logic [3:0]      rd_data;
  logic            store_load;
  logic [1:0]      fail_next;
  logic            key_dig;

  assign key_dig   = is_digit(bus.key);
  assign fail_next = fail_cnt + 2'd1;

  // LOCKED always compares against position 0; ENTRY uses the running count.
  assign rd_addr = (state == ENTRY) ? digit_cnt[1:0] : 2'd0;

  assign store_load = (state == SET_NEW) && bus.key_valid &&
                      (bus.key == KEY_HASH) && (digit_cnt == 3'd4);

  pw_store u_store (
    .clk       (clk),
    .reset     (reset),
    .we        (1'b0),
    .waddr     (2'd0),
    .wdata     (4'd0),
    .load      (store_load),
    .load_data (staging),
    .raddr     (rd_addr),
    .rdata     (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOCKED;
      fail_cnt  <= '0;
      digit_cnt <= '0;
      mismatch  <= 1'b0;
      lock_cnt  <= '0;
      staging   <= '0;
      bad_pulse <= 1'b0;
    end else begin
      bad_pulse <= 1'b0;
      if (state == ALARM) begin
        // Lockout runs regardless of keypresses.
        if (lock_cnt == '0) begin
          state    <= LOCKED;
          fail_cnt <= '0;
        end else begin
          lock_cnt <= lock_cnt - 1'b1;
        end
      end else if (bus.key_valid) begin
        unique case (state)
          LOCKED: begin
            if (key_dig) begin
              mismatch  <= (bus.key != rd_data);
              digit_cnt <= 3'd1;
              state     <= ENTRY;
            end
          end
          ENTRY: begin
            if (key_dig) begin
              if (digit_cnt < 3'd4) begin
                mismatch  <= mismatch | (bus.key != rd_data);
                digit_cnt <= digit_cnt + 3'd1;
              end else begin
                mismatch  <= 1'b1;
                digit_cnt <= 3'd5;
              end
            end else if (bus.key == KEY_STAR) begin
              digit_cnt <= '0;
              mismatch  <= 1'b0;
              state     <= LOCKED;
            end else if (bus.key == KEY_HASH) begin
              digit_cnt <= '0;
              mismatch  <= 1'b0;
              if ((digit_cnt == 3'd4) && !mismatch) begin
                fail_cnt <= '0;
                state    <= UNLOCKED;
              end else begin
                bad_pulse <= 1'b1;
                fail_cnt  <= fail_next;
                if (32'(fail_next) == MAX_FAILS) begin
                  lock_cnt <= CW'(LOCKOUT_CYCLES - 1);
                  state    <= ALARM;
                end else begin
                  state <= LOCKED;
                end
              end
            end
          end
          UNLOCKED: begin
            if (bus.key == KEY_HASH) begin
              state <= LOCKED;
            end else if (bus.key == KEY_STAR) begin
              digit_cnt <= '0;
              state     <= SET_NEW;
            end
          end
          SET_NEW: begin
            if (key_dig) begin
              if (digit_cnt < 3'd4) begin
                staging[digit_cnt[1:0]] <= bus.key;
              end
              if (digit_cnt < 3'd5) begin
                digit_cnt <= digit_cnt + 3'd1;
              end
            end else if ((bus.key == KEY_HASH) || (bus.key == KEY_STAR)) begin
              // Store load for '#' happens through store_load this same cycle.
              staging   <= '0;
              digit_cnt <= '0;
              state     <= UNLOCKED;
            end
          end
          default: state <= LOCKED;
        endcase
      end
    end
  end

  assign bus.unlocked  = (state == UNLOCKED) || (state == SET_NEW);
  assign bus.alarm     = (state == ALARM);
  assign bus.fail_cnt  = fail_cnt;
  assign bus.digit_cnt = digit_cnt;
  assign bus.bad_pulse = bad_pulse;
  assign bus.state_o   = state;

endmodule

// File: tb/tb_lock_controller.sv
// Directed self-checking bench for lock_controller.
module tb_lock_controller;
  import lock_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  lock_controller_if bus ();

  lock_controller #(
    .LOCKOUT_CYCLES (16),
    .MAX_FAILS      (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] S = 4'b1010;
  localparam logic [3:0] H = 4'b1011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one keypress for one cycle; returns at the following negedge,
  // where the response to that key is visible.
  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key       = k;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key       = 4'd0;
  endtask

  task automatic code4(input logic [3:0] a, b, c, d);
    press(a); press(b); press(c); press(d);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    bus.key_valid = 1'b0;
    bus.key = 4'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_unlocked", 32'(bus.unlocked), 0);
    chk("rst_alarm", 32'(bus.alarm), 0);
    chk("rst_bad", 32'(bus.bad_pulse), 0);
    chk("rst_state", 32'(bus.state_o), 0);
    chk("rst_fail", 32'(bus.fail_cnt), 0);
    chk("rst_digits", 32'(bus.digit_cnt), 0);
    reset = 1'b0;
    @(negedge clk);

    // Ignored keys while LOCKED
    press(4'hC); chk("lock_ign_c", 32'(bus.state_o), 0);
    press(H);    chk("lock_ign_hash_st", 32'(bus.state_o), 0);
    chk("lock_ign_hash_bad", 32'(bus.bad_pulse), 0);

    // Default code 0000 unlocks
    press(4'd0); chk("entry_state", 32'(bus.state_o), 1);
    chk("entry_d1", 32'(bus.digit_cnt), 1);
    press(4'd0); press(4'hF); press(4'd0); press(4'd0);
    chk("entry_d4", 32'(bus.digit_cnt), 4);
    press(H);
    chk("unlock0_u", 32'(bus.unlocked), 1);
    chk("unlock0_fail", 32'(bus.fail_cnt), 0);
    chk("unlock0_dc", 32'(bus.digit_cnt), 0);

    // Change code to 1234
    press(4'd5); chk("unl_digit_ign", 32'(bus.state_o), 2);
    press(S);    chk("setnew_state", 32'(bus.state_o), 3);
    chk("setnew_u", 32'(bus.unlocked), 1);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("setnew_dc", 32'(bus.digit_cnt), 4);
    press(H); chk("setnew_done", 32'(bus.state_o), 2);
    press(H); chk("relock", 32'(bus.unlocked), 0);
    code4(4'd1, 4'd2, 4'd3, 4'd4); press(H);
    chk("unlock1234", 32'(bus.unlocked), 1);
    press(H);
    code4(4'd0, 4'd0, 4'd0, 4'd0); press(H);
    chk("old_code_bad", 32'(bus.bad_pulse), 1);
    chk("old_code_fail", 32'(bus.fail_cnt), 1);
    chk("old_code_st", 32'(bus.state_o), 0);
    @(negedge clk);
    chk("bad_one_cycle", 32'(bus.bad_pulse), 0);

    // Pass clears fail count
    code4(4'd1, 4'd2, 4'd3, 4'd4); press(H);
    chk("pass_clr_fail", 32'(bus.fail_cnt), 0);
    press(H);

    // Three failures -> alarm
    code4(4'd1, 4'd1, 4'd1, 4'd1); press(H);
    chk("f1", 32'(bus.fail_cnt), 1);
    code4(4'd1, 4'd1, 4'd1, 4'd1); press(H);
    chk("f2", 32'(bus.fail_cnt), 2);
    code4(4'd1, 4'd1, 4'd1, 4'd1); press(H);
    chk("f3_fail", 32'(bus.fail_cnt), 3);
    chk("f3_bad", 32'(bus.bad_pulse), 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("alarm_c%0d", i), 32'(bus.alarm), 1);
      bus.key_valid = 1'b1;
      bus.key = (i % 5 == 4) ? H : 4'(i % 5 + 1);
      @(negedge clk);
    end
    bus.key_valid = 1'b0;
    chk("alarm_end", 32'(bus.alarm), 0);
    chk("alarm_state", 32'(bus.state_o), 0);
    chk("alarm_fail_clr", 32'(bus.fail_cnt), 0);
    chk("alarm_dc", 32'(bus.digit_cnt), 0);

    // Five digits, then three digits
    code4(4'd1, 4'd2, 4'd3, 4'd4); press(4'd0);
    chk("five_dc", 32'(bus.digit_cnt), 5);
    press(4'd0); chk("six_dc", 32'(bus.digit_cnt), 5);
    press(H);
    chk("five_bad", 32'(bus.bad_pulse), 1);
    chk("five_fail", 32'(bus.fail_cnt), 1);
    press(4'd1); press(4'd2); press(4'd3); press(H);
    chk("three_bad", 32'(bus.bad_pulse), 1);
    chk("three_fail", 32'(bus.fail_cnt), 2);

    // '*' in ENTRY aborts without touching fail count
    press(4'd1); press(4'd2); press(S);
    chk("star_st", 32'(bus.state_o), 0);
    chk("star_dc", 32'(bus.digit_cnt), 0);
    chk("star_fail", 32'(bus.fail_cnt), 2);
    code4(4'd1, 4'd2, 4'd3, 4'd4); press(H);
    chk("unlock_again", 32'(bus.unlocked), 1);

    // SET_NEW aborted by '*', short '#', and over-long entry: store kept
    press(S); press(4'd7); press(4'd7); press(S);
    chk("sn_star_st", 32'(bus.state_o), 2);
    press(S); press(4'd7); press(4'd7); press(H);
    chk("sn_short_st", 32'(bus.state_o), 2);
    press(S); code4(4'd7, 4'd7, 4'd7, 4'd7); press(4'd7);
    chk("sn_sat", 32'(bus.digit_cnt), 5);
    press(H);
    press(H);
    code4(4'd1, 4'd2, 4'd3, 4'd4); press(H);
    chk("store_kept", 32'(bus.unlocked), 1);

    // Reset mid SET_NEW
    press(S); press(4'd5); press(4'd5); press(4'd5);
    #2 reset = 1'b1;
    #1;
    chk("midrst_u", 32'(bus.unlocked), 0);
    chk("midrst_st", 32'(bus.state_o), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    code4(4'd0, 4'd0, 4'd0, 4'd0); press(H);
    chk("rst_store0", 32'(bus.unlocked), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lock_controller.md
LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 Parameter LOCKOUT_CYCLES, default 16: cycles spent in ALARM before returning to LOCKED.
REQ-002 Parameter MAX_FAILS, default 3: consecutive failed attempts that trigger ALARM.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 key_valid  input  1  one-cycle strobe: key holds a new keypress.
REQ-006 key  input  4  key code; 0-9 digit, 4'b1010 '*', 4'b1011 '#', others ignored.
REQ-007 unlocked  output  1  high while in UNLOCKED or SET_NEW.
REQ-008 alarm  output  1  high while in ALARM.
REQ-009 fail_cnt  output  2  consecutive failed attempts.
REQ-010 digit_cnt  output  3  digits entered in the current sequence, saturating at 5.
REQ-011 bad_pulse  output  1  one-cycle pulse on each failed '#' evaluation.
REQ-012 state_o  output  3  current FSM state encoding, for debug.

Function
REQ-013 The block SHALL hold a 4-entry x 4-bit password store, addressed by digit position 0-3.
REQ-014 The FSM SHALL have the states LOCKED, ENTRY, UNLOCKED, SET_NEW and ALARM.
REQ-015 A key SHALL be acted on only in a cycle with key_valid=1; codes 12-15 SHALL be ignored in every state.
REQ-016 LOCKED, digit: the block SHALL compare the digit with store[0], set mismatch if unequal, set digit_cnt=1 and go to ENTRY; '*' and '#' SHALL be ignored.
REQ-017 ENTRY, digit: while digit_cnt<4, the block SHALL compare the digit with store[digit_cnt], OR the result into a sticky mismatch flag and increment digit_cnt; a 5th digit SHALL set digit_cnt=5 and force mismatch; further digits SHALL leave digit_cnt at 5.
REQ-018 ENTRY, '*': the block SHALL clear the entry (digit_cnt=0, mismatch=0) and go to LOCKED, leaving fail_cnt unchanged.
REQ-019 ENTRY, '#': the entry SHALL pass iff digit_cnt==4 and mismatch==0.
REQ-020 Pass: go to UNLOCKED and clear fail_cnt.
REQ-021 Fail: pulse bad_pulse for one cycle and increment fail_cnt; if the new fail_cnt equals MAX_FAILS, go to ALARM, otherwise go to LOCKED.
REQ-022 On leaving ENTRY, digit_cnt and mismatch SHALL be cleared.
REQ-023 UNLOCKED: '#' SHALL go to LOCKED; '*' SHALL go to SET_NEW with digit_cnt=0; digits SHALL be ignored.
REQ-024 SET_NEW, digit: the digit SHALL be written to staging[digit_cnt] while digit_cnt<4, then digit_cnt SHALL increment (saturating at 5).
REQ-025 SET_NEW, '#': if digit_cnt==4, all four staging entries SHALL be copied into the store in the same cycle; in all cases the block SHALL return to UNLOCKED.
REQ-026 SET_NEW, '*': staging SHALL be discarded, the store SHALL stay unchanged, and the block SHALL return to UNLOCKED.
REQ-027 ALARM: a down-counter SHALL load LOCKOUT_CYCLES-1 on entry; all keys SHALL be ignored; at count 0 the block SHALL go to LOCKED and clear fail_cnt.
REQ-028 All outputs SHALL be registered or decoded directly from state registers, with no combinational path from key to any output.
REQ-029 A response SHALL appear one cycle after the key_valid cycle.

Reset
REQ-030 Reset SHALL force state=LOCKED, store={0,0,0,0}, staging=0, fail_cnt=0, digit_cnt=0, mismatch=0, lockout counter=0.
REQ-031 During reset the outputs SHALL be: unlocked=0, alarm=0, bad_pulse=0.
REQ-032 Reset asserted mid-entry, mid-SET_NEW or mid-ALARM SHALL abort the operation with no store write.

Structure
REQ-033 A shared package lock_pkg SHALL hold the state enum, KEY_STAR=4'b1010, KEY_HASH=4'b1011 and the digit-range check.
REQ-034 The password store SHALL be a sub-module pw_store: 4x4 registers with a single-entry write port, a 4-word parallel load and an async read port.

Verification
REQ-035 Reset, keys 0,0,0,0,# -> unlocked=1 one cycle after '#'; fail_cnt=0.
REQ-036 Unlocked, keys *,1,2,3,4,#,#, then 1,2,3,4,# -> relocks, then unlocked=1; the old code 0000 then fails with bad_pulse.
REQ-037 Keys 1,1,1,1,# three times -> fail_cnt goes 1,2, then alarm=1 for 16 cycles with keys ignored, then LOCKED with fail_cnt=0.
REQ-038 Keys 0,0,0,0,0,# (5 digits) -> fail, digit_cnt=5 before '#'; keys 0,0,0,# (3 digits) -> fail.
REQ-039 SET_NEW with keys 7,7,* -> store still 0000; SET_NEW with keys 7,7,# (2 digits) -> store unchanged, back in UNLOCKED.
REQ-040 Reset asserted after keys *,5,5,5 in SET_NEW -> LOCKED, store=0000, unlocked=0 immediately.
